// File: rtl/data_cache_pkg.sv
// Shared types for the L1 data cache.
//   - address split widths (tag / set / word-in-line)
//   - cache_state_t controller states
//   - helpers that pull the tag, set and word fields out of a byte address
//     and rebuild a line-aligned address from a tag and set.
package cache_types;

  localparam int S_INDEX      = 3;                    // set-index bits
  localparam int S_OFFSET     = 5;                    // line-offset bits
  localparam int S_LINE       = 256;                  // line width in bits
  localparam int S_SETS       = 2 ** S_INDEX;
  localparam int S_TAG        = 32 - S_INDEX - S_OFFSET;
  localparam int S_WORD       = S_OFFSET - 2;         // word-in-line index bits
  localparam int S_LINE_BYTES = S_LINE / 8;

  typedef logic [S_TAG-1:0]   tag_t;
  typedef logic [S_INDEX-1:0] set_t;
  typedef logic [S_WORD-1:0]  word_t;
  typedef logic [S_LINE-1:0]  line_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

  function automatic tag_t addr_tag(input logic [31:0] addr);
    return addr[31:S_INDEX+S_OFFSET];
  endfunction

  function automatic set_t addr_set(input logic [31:0] addr);
    return addr[S_INDEX+S_OFFSET-1:S_OFFSET];
  endfunction

  function automatic word_t addr_word(input logic [31:0] addr);
    return addr[S_OFFSET-1:2];
  endfunction

  function automatic logic [31:0] line_addr(input tag_t tag, input set_t set);
    return {tag, set, {S_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// Bus bundle for the data cache.
//   mem_*  : pipeline MEM-stage data port (requester side)
//   pmem_* : physical-memory cacheline port
// Modports:
//   slave  : the cache's view (serves mem_*, drives pmem_* requests)
//   master : the environment's view (pipeline + physical memory)
interface data_cache_if;
  import cache_types::*;

  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  line_t       pmem_wdata;
  line_t       pmem_rdata;
  logic        pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/data_cache_data_array.sv
// Line storage for the data cache: S_SETS lines of S_LINE bits in flops.
// Ports:
//   clk       : clock
//   set_idx   : line selected for both read and write
//   fill      : replace the whole line with fill_data (takes priority)
//   fill_data : incoming line from physical memory
//   wdata     : store word, replicated across every word slot of the line
//   byte_mask : one bit per byte of the line; set bits take the wdata byte
//   rline     : current contents of the selected line (combinational)
// The contents are not reset; the tag/valid logic decides what is meaningful.
module cache_data_array
  import cache_types::*;
(
  input  logic                    clk,
  input  set_t                    set_idx,
  input  logic                    fill,
  input  line_t                   fill_data,
  input  logic [31:0]             wdata,
  input  logic [S_LINE_BYTES-1:0] byte_mask,
  output line_t                   rline
);

  line_t data [S_SETS];

  always_ff @(posedge clk) begin
    if (fill) begin
      data[set_idx] <= fill_data;
    end else begin
      for (int b = 0; b < S_LINE_BYTES; b++) begin
        // Byte b of the line lives in lane (b % 4) of its word.
        if (byte_mask[b]) data[set_idx][b*8 +: 8] <= wdata[(b%4)*8 +: 8];
      end
    end
  end

  assign rline = data[set_idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// Ports:
//   clk : clock
//   rst : asynchronous active-high reset (clears valid, dirty and state)
//   bus : data_cache_if.slave -- MEM-stage port in, cacheline port out
// Hits complete combinationally in the request cycle; misses stall the
// requester (mem_resp low) while the victim is written back and the new
// line is fetched. After a fill the request hits on the following cycle.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | serve hits; on a miss pick WRITEBACK (dirty victim) or ALLOCATE
// WRITEBACK | pmem_write the victim line until pmem_resp
// ALLOCATE  | pmem_read the requested line until pmem_resp, then install it
module data_cache
  import cache_types::*;
(
  input  logic         clk,
  input  logic         rst,
  data_cache_if.slave  bus
);

  cache_state_t            state;
  logic [S_SETS-1:0]       valid;
  logic [S_SETS-1:0]       dirty;
  tag_t                    tags [S_SETS];

  tag_t                    req_tag;
  set_t                    req_set;
  word_t                   req_word;
  logic                    req;
  logic                    hit;
  logic                    fill;
  logic [S_LINE_BYTES-1:0] byte_mask;
  line_t                   line;
  logic [1:0]              unused_addr_lsb;

  assign req_tag         = addr_tag(bus.mem_address);
  assign req_set         = addr_set(bus.mem_address);
  assign req_word        = addr_word(bus.mem_address);
  assign unused_addr_lsb = bus.mem_address[1:0];

  assign req  = bus.mem_read | bus.mem_write;
  assign hit  = valid[req_set] && (tags[req_set] == req_tag);
  assign fill = (state == ALLOCATE) && bus.pmem_resp;

  // Store-hit merge: shift the 4 lane enables into the addressed word.
  assign byte_mask = (state == IDLE && bus.mem_write && hit)
                   ? ({{(S_LINE_BYTES-4){1'b0}}, bus.mem_byte_enable} << {req_word, 2'b00})
                   : '0;

  cache_data_array u_data (
    .clk       (clk),
    .set_idx   (req_set),
    .fill      (fill),
    .fill_data (bus.pmem_rdata),
    .wdata     (bus.mem_wdata),
    .byte_mask (byte_mask),
    .rline     (line)
  );

  assign bus.mem_resp   = (state == IDLE) && req && hit;
  assign bus.mem_rdata  = line[{req_word, 5'b0} +: 32];
  assign bus.pmem_read  = (state == ALLOCATE);
  assign bus.pmem_write = (state == WRITEBACK);
  assign bus.pmem_wdata = line;

  always_comb begin
    bus.pmem_address = '0;
    case (state)
      WRITEBACK: bus.pmem_address = line_addr(tags[req_set], req_set);
      ALLOCATE:  bus.pmem_address = line_addr(req_tag, req_set);
      default:   bus.pmem_address = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            // dirty implies valid, so a dirty miss always has a real victim
            state <= dirty[req_set] ? WRITEBACK : ALLOCATE;
          end else if (bus.mem_write && hit) begin
            dirty[req_set] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (bus.pmem_resp) state <= ALLOCATE;
        end
        ALLOCATE: begin
          // The fill completes even if the requester has dropped its request.
          if (bus.pmem_resp) begin
            valid[req_set] <= 1'b1;
            dirty[req_set] <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tags carry no reset; a tag only matters once valid is set for its set.
  always_ff @(posedge clk) begin
    if (fill) tags[req_set] <= req_tag;
  end

endmodule
